// File: rtl/arbiter_rr_param_if.sv
// Request/grant bundle between N masters and the arbiter.
//   req       : master -> arbiter, one bit per requester, level-sensitive
//   gnt       : arbiter -> master, one-hot (or zero) registered grant
//   gnt_valid : arbiter -> master, OR of gnt
//   gnt_id    : arbiter -> master, index of granted requester (0 when idle)
interface arbiter_rr_param_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;

    modport master (output req, input gnt, gnt_valid, gnt_id);
    modport slave  (input req, output gnt, gnt_valid, gnt_id);
endinterface

// File: rtl/arbiter_rr_param.sv
// N-way arbiter onto a single shared resource, registered one-hot grant.
//   MODE 0 : slot polling, requester i owns every N-th cycle.
//   MODE 1 : work-conserving round-robin with grant hold; MAX_HOLD caps the
//            consecutive cycles an owner keeps the grant while others wait.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : arbiter_rr_param_if.slave (req in; gnt, gnt_valid, gnt_id out)
module arbiter_rr_param #(
    parameter int N        = 4,
    parameter int MODE     = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    arbiter_rr_param_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [N-1:0]  ONE  = N'(1);
    localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SLOT = 2'd1, GRANT = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;   // round-robin priority head, or slot in MODE 0
    logic [HW-1:0] hold_q, hold_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] id_q, id_d;     // doubles as the current owner
    logic          vld_q;
    logic [N-1:0]  req;
    logic          others;
    logic [IW-1:0] nxt;

    assign req           = bus.req;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = vld_q;
    assign bus.gnt_id    = id_q;

    // Modulo-N increment, correct for non-power-of-2 N.
    function automatic logic [IW-1:0] inc(input logic [IW-1:0] s);
        return (s == LAST) ? '0 : s + 1'b1;
    endfunction

    // First requesting index scanning s, s+1, ..., wrapping. Scanned from
    // the far end so the closest hit is the last one written.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] r, input logic [IW-1:0] s);
        logic [IW-1:0] p;
        int            t;
        p = '0;
        for (int k = N - 1; k >= 0; k--) begin
            t = int'(s) + k;
            if (t >= N) t = t - N;
            if (r[IW'(t)]) p = IW'(t);
        end
        return p;
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        others  = |(req & ~(ONE << id_q));
        nxt     = '0;
        if (MODE == 0) begin
            case (state_q)
                SLOT: begin
                    gnt_d = req[ptr_q] ? (ONE << ptr_q) : '0;
                    id_d  = req[ptr_q] ? ptr_q : '0;
                    ptr_d = inc(ptr_q);
                end
                default: begin
                    state_d = SLOT;
                    ptr_d   = '0;
                    gnt_d   = '0;
                    id_d    = '0;
                end
            endcase
        end else begin
            case (state_q)
                GRANT: begin
                    if (!req[id_q]) begin
                        // Release: the old owner goes to the back of the queue.
                        ptr_d = inc(id_q);
                        if (|req) begin
                            nxt    = pick(req, inc(id_q));
                            id_d   = nxt;
                            gnt_d  = ONE << nxt;
                            hold_d = HW'(1);
                        end else begin
                            state_d = IDLE;
                            gnt_d   = '0;
                            id_d    = '0;
                            hold_d  = '0;
                        end
                    end else if (MAX_HOLD != 0 && hold_q == HMAX && others) begin
                        // Hold limit reached with waiters: owner is scanned last.
                        nxt    = pick(req, inc(id_q));
                        id_d   = nxt;
                        gnt_d  = ONE << nxt;
                        ptr_d  = inc(id_q);
                        hold_d = HW'(1);
                    end else if (MAX_HOLD != 0 && hold_q != HMAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                    hold_d  = '0;
                    if (|req) begin
                        nxt     = pick(req, ptr_q);
                        state_d = GRANT;
                        id_d    = nxt;
                        gnt_d   = ONE << nxt;
                        hold_d  = HW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            id_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            vld_q   <= |gnt_d;
        end
    end
endmodule

// File: tb/tb_arbiter_rr_param.sv
// Directed bench: a round-robin instance (N=4, MAX_HOLD=2) and a slot
// polling instance (N=3) sharing clock and reset.
module tb_arbiter_rr_param;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    arbiter_rr_param_if #(.N(4)) if4 ();
    arbiter_rr_param_if #(.N(3)) if3 ();

    arbiter_rr_param #(.N(4), .MODE(1), .MAX_HOLD(2)) u_rr (
        .clk (clk),
        .rst (rst_n),
        .bus (if4.slave)
    );

    arbiter_rr_param #(.N(3), .MODE(0), .MAX_HOLD(2)) u_sp (
        .clk (clk),
        .rst (rst_n),
        .bus (if3.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] g, input int id);
        chk({tag, ".gnt"}, 32'(if4.gnt), 32'(g));
        chk({tag, ".id"},  32'(if4.gnt_id), 32'(id));
        chk({tag, ".vld"}, 32'(if4.gnt_valid), 32'(|g));
    endtask

    task automatic chk3(input string tag, input logic [2:0] g, input int id);
        chk({tag, ".gnt"}, 32'(if3.gnt), 32'(g));
        chk({tag, ".id"},  32'(if3.gnt_id), 32'(id));
        chk({tag, ".vld"}, 32'(if3.gnt_valid), 32'(|g));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] seq_id [10];
        logic [2:0] sp_g   [6];
        int         sp_id  [6];
        seq_id = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        sp_g   = '{3'b000, 3'b100, 3'b001, 3'b000, 3'b100, 3'b001};
        sp_id  = '{0, 2, 0, 0, 2, 0};

        rst_n  = 1'b0;
        if4.req = '0;
        if3.req = '0;

        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk4("rst_rr", 4'b0000, 0);
            chk3("rst_sp", 3'b000, 0);
        end
        rst_n = 1'b1;

        // Idle after release; slot poller advances with no requests
        for (int i = 0; i < 5; i++) begin
            step();
            chk4("idle_rr", 4'b0000, 0);
            chk3("idle_sp", 3'b000, 0);
        end

        // Slot polling with req=101: slot is 1 at this point
        if3.req = 3'b101;
        for (int i = 0; i < 6; i++) begin
            step();
            chk3("slot", sp_g[i], sp_id[i]);
        end
        if3.req = 3'b000;

        // Single requester
        if4.req = 4'b0100;
        step(); chk4("single0", 4'b0100, 2);
        step(); chk4("single1", 4'b0100, 2);
        if4.req = 4'b0000;
        step(); chk4("single_drop", 4'b0000, 0);

        // Reset pulse so the fairness run starts from ptr=0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Fairness and wrap with MAX_HOLD=2
        if4.req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            step();
            chk4("fair", 4'b0001 << seq_id[i], int'(seq_id[i]));
        end

        // Owner 0 releases, only 3 requests
        if4.req = 4'b1000;
        step(); chk4("rel_to3", 4'b1000, 3);
        if4.req = 4'b1011;
        step(); chk4("hold3", 4'b1000, 3);
        // Owner 3 releases with 0 and 1 waiting: no bubble
        if4.req = 4'b0011;
        step(); chk4("rel_nobubble", 4'b0001, 0);
        step(); chk4("hold0", 4'b0001, 0);
        step(); chk4("expire_to1", 4'b0010, 1);

        // Lone owner keeps the grant past MAX_HOLD
        if4.req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            step();
            chk4("lone", 4'b0100, 2);
        end

        // Owner 2 releases; it re-asserts next cycle and must wait for 3 and 0
        if4.req = 4'b1001;
        step(); chk4("rel2_to3", 4'b1000, 3);
        if4.req = 4'b1101;
        step(); chk4("wait_a", 4'b1000, 3);
        step(); chk4("wait_b", 4'b0001, 0);
        step(); chk4("wait_c", 4'b0001, 0);
        step(); chk4("wait_turn2", 4'b0100, 2);

        // Asynchronous reset mid-grant
        #3;
        rst_n = 1'b0;
        #1;
        chk4("rst_mid", 4'b0000, 0);
        if4.req = 4'b1100;
        step(); chk4("rst_hold", 4'b0000, 0);
        rst_n = 1'b1;
        step(); chk4("post_rst", 4'b0100, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arbiter_rr_param.md
Name: arbiter_rr_param

Overview:
- Parametrised successor to the team's fixed 3-input polling arbiter.
- Arbitrates N request lines onto a one-hot registered grant. It supports two modes:
  - Legacy slot polling.
  - Work-conserving round-robin with grant hold and a hold-time limit.
- Sits between multiple masters and a single shared resource (bus, memory port).

Parameters:
- N, 4, number of requesters (2..16).
- MODE, 1, 0 = slot polling (fixed time slots); 1 = work-conserving round-robin.
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others wait (MODE 1 only); 0 = unlimited.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- req  input  N  request vector, bit i = requester i; level-sensitive.
- gnt  output  N  one-hot (or zero) grant vector, registered.
- gnt_valid  output  1  OR of gnt, registered.
- gnt_id  output  max(1,$clog2(N))  index of the granted requester; 0 when gnt_valid=0.

Behaviour:
- Reset (rst=0, asynchronous): gnt=0, gnt_valid=0, gnt_id=0, ptr=0, hold_cnt=0, state=IDLE. All outputs come directly from flops and are never combinational from req.
- Latency: req sampled at edge k is reflected on gnt after edge k, so the grant is visible in the cycle after the request is asserted.
- At most one gnt bit is high in any cycle. A gnt bit is never high for a requester whose req was low at the preceding edge.
- ptr is a max(1,$clog2(N))-bit highest-priority index. It wraps N-1 -> 0; the increment is modulo N, including non-power-of-2 N.
- pick(s) = first index i in s, s+1, ..., N-1, 0, ..., s-1 with req[i]=1.
- MODE 0 (slot polling), states IDLE -> SLOT:
  - IDLE: on the first edge after reset release, move to SLOT with slot=0.
  - SLOT: each edge, gnt <= onehot(slot) & {N{req[slot]}}, then slot <= slot+1 mod N.
  - The slot advances every cycle regardless of req, so each requester gets 1 cycle in N.
- MODE 1 (round-robin), states IDLE and GRANT:
  - IDLE, no req: stay in IDLE, gnt=0.
  - IDLE, any req: owner <= pick(ptr), gnt <= onehot(owner), hold_cnt <= 1, go to GRANT.
  - GRANT, req[owner]=0 (release): ptr <= owner+1.
    - If others request: re-arbitrate in the same edge with pick(owner+1), hold_cnt <= 1. There is no idle bubble.
    - Otherwise: go to IDLE, gnt <= 0.
  - GRANT, req[owner]=1, and MAX_HOLD!=0, hold_cnt==MAX_HOLD, and another req bit set (expiry): forced switch.
    - owner <= pick(owner+1), ptr <= owner+1, hold_cnt <= 1.
  - GRANT, req[owner]=1, otherwise: keep grant. hold_cnt increments and saturates at MAX_HOLD; with MAX_HOLD=0 it does not count.
  - An owner alone on the bus keeps the grant indefinitely, even past MAX_HOLD.
- Simultaneous release and new requests: the releasing requester has the lowest priority for that re-arbitration.
- A requester re-asserting in the cycle right after release waits its round-robin turn.
- Reset mid-grant: outputs clear immediately (asynchronous). After release, arbitration restarts from ptr=0.
- hold_cnt width is max(1,$clog2(MAX_HOLD+1)). No X propagation: all unused states decode to IDLE.

Test Plan:
- Reset then idle: rst low 3 cycles, req=0 for 5 cycles -> gnt=0, gnt_valid=0, gnt_id=0 throughout.
- Single requester, MODE 1, N=4: req=4'b0100 at edge 1 -> gnt=4'b0100, gnt_id=2 from the cycle after edge 1; drop req -> gnt=0 the next cycle.
- Fairness and wrap, MODE 1, MAX_HOLD=2, req=4'b1111 held -> grant sequence 0,0,1,1,2,2,3,3,0,0; each owner holds exactly 2 cycles, and the grant wraps 3 -> 0.
- Release re-arbitration: owner 3 drops req while req[0] and req[1] are high -> next cycle gnt=4'b0001 with no zero-grant cycle. A lone owner with MAX_HOLD=2 keeps the grant 10 cycles.
- Slot polling, MODE 0, N=3, req=3'b101 constant -> gnt pattern 001, 000, 100 repeating; with req=0, gnt stays 0 while slots keep advancing.
- Reset mid-grant, MODE 1: owner 2 granted, rst asserted mid-cycle -> gnt=0 before the next edge. After release with req=4'b1100 -> first grant goes to index 2 (ptr=0 scan).
